tpu_sequencer: RTL and testbench
================================

# tpu_sequencer

Sequencer for the 4x4 systolic matrix-multiply datapath. After a single `start` pulse it drives the per-line read enables and element indices of memories A and B in the diagonal skew pattern the array needs, and holds the array write enable for the feed and propagate window. It then streams the 16 accumulated results out in row-major order as row/column selects under a valid/ready handshake. It sits between the instruction control unit, which issues `start`, and the memory/array/result-mux datapath.

## Interface
- `N`, 4: array dimension. Only 4 is supported; index fields are 2 bits.
- `FLUSH_CYCLES`, 1: extra cycles `array_we` stays high after FEED, to cover memory read and array pipeline latency. Legal range is 1-7.
- `clk`  in  1  single clock; everything is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  launch request; sampled only in IDLE.
- `busy`  out  1  high in FEED, FLUSH and DRAIN.
- `done`  out  1  one-cycle pulse after the last result is accepted.
- `rd_en_a`  out  4  memory A per-line read enable; bit i is line i.
- `rd_elem_a`  out  8  memory A element index; bits [2i+1:2i] belong to line i.
- `rd_en_b`  out  4  memory B per-line read enable.
- `rd_elem_b`  out  8  memory B element index, same packing as A.
- `array_we`  out  1  array compute/write enable.
- `out_row`  out  2  result row select.
- `out_col`  out  2  result column select.
- `out_valid`  out  1  `out_row`/`out_col` address a valid result.
- `out_ready`  in  1  consumer accepts the current result.

## Operation
- State register has four states: IDLE, FEED, FLUSH, DRAIN. A 4-bit step counter `t` and a 4-bit result index `k` are also registered. All outputs are decoded from registered state only.
- IDLE:
  - All outputs are 0.
  - `start`=1 moves to FEED with `t`=0.
- FEED runs 3N-2 = 10 cycles, `t` = 0..9.
  - For line i: `rd_en_a[i]` = `rd_en_b[i]` = 1 iff 0 <= t-i <= 3.
  - Each enabled line's elem field = (t-i)[1:0]. Disabled lines' fields are 0.
  - A and B always carry identical patterns.
  - `array_we`=1 throughout FEED.
  - When `t`=9, go to FLUSH.
- FLUSH lasts `FLUSH_CYCLES` cycles. `array_we`=1, read enables are 0. Then go to DRAIN with `k`=0.
- DRAIN:
  - `out_valid`=1, `out_row`=k[3:2], `out_col`=k[1:0].
  - `k` increments only on `out_valid && out_ready`.
  - Acceptance at `k`=15 goes to IDLE and pulses `done` in that first IDLE cycle.
  - `array_we`=0 and read enables are 0.
- `start` outside IDLE is ignored. It is not queued.
- `start` in the same cycle `done` is high is accepted normally, giving back-to-back runs.
- The counter `t` never wraps within FEED. `k` wraps 15→0 only via the exit to IDLE.
- Reset asserted at any time, including mid-FEED or mid-DRAIN, immediately forces IDLE and clears `t`, `k`, `done` and all outputs. No partial run resumes.

## Timing
- Reset values: every output is 0 and the state is IDLE.
- `start` sampled high at edge 0 produces:
  - FEED at cycles 1-10.
  - FLUSH at cycles 11..10+`FLUSH_CYCLES`.
  - DRAIN after that.
- `busy` rises one cycle after `start`.
- With `out_ready` held at 1, DRAIN takes exactly 16 cycles.
- Total latency from `start` to `done` is 11 + `FLUSH_CYCLES` + 16 cycles; with defaults this is `done` in cycle 28.
- Each cycle `out_ready` is 0 during DRAIN adds one cycle. Row/col stay stable while `out_valid && !out_ready`.
- `busy` falls in the same cycle `done` rises.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → all outputs read 0 immediately. After release, the block is idle with `busy`=0.
- Feed pattern, `start` at edge 0:
  - Cycle 1: `rd_en_a`=4'b0001, `rd_elem_a`=8'h00.
  - Cycle 4: `rd_en`=4'b1111, `rd_elem`=8'h1B.
  - Cycle 7: `rd_en`=4'b1000, `rd_elem`=8'hC0.
  - Cycles 8-10: `rd_en`=0, `array_we`=1.
  - A and B are identical in every cycle.
- Drain with `out_ready`=1 → `out_row`/`out_col` step (0,0),(0,1)…(3,3) in cycles 12-27. `done`=1 only in cycle 28, and `busy`=0 in cycle 28.
- Backpressure: `out_ready`=0 for 3 cycles at `k`=5 → `out_row`=1 and `out_col`=1 hold steady, and `done` slips to cycle 31.
- `start` pulsed in cycles 3 and 15 → no effect. `done` stays at cycle 28.
- Back-to-back and abort:
  - `start` held in cycle 28 → a new FEED begins in cycle 29.
  - `rst` pulsed in cycle 6 → outputs are 0 at once, and a later `start` runs a full correct sequence.

Source files
------------

// File: rtl/tpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tpu_sequencer
//  Brief    : Sequencer for the 4x4 systolic matrix-multiply datapath.
//             Drives skewed A/B memory reads during FEED, holds the array
//             write enable through FLUSH, then streams the 16 results out
//             in row-major order under a valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tpu_sequencer #(
    parameter int N            = 4,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [N-1:0]     rd_en_a,
    output logic [2*N-1:0]   rd_elem_a,
    output logic [N-1:0]     rd_en_b,
    output logic [2*N-1:0]   rd_elem_b,
    output logic             array_we,
    output logic [1:0]       out_row,
    output logic [1:0]       out_col,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FEED  = 2'd1;
    localparam logic [1:0] c_ST_FLUSH = 2'd2;
    localparam logic [1:0] c_ST_DRAIN = 2'd3;

    // Last step index of FEED (3N-2 cycles), last FLUSH step, last result.
    localparam logic [3:0] c_FEED_LAST  = 4'(3*N-3);
    localparam logic [3:0] c_FLUSH_LAST = 4'(FLUSH_CYCLES-1);
    localparam logic [3:0] c_K_LAST     = 4'(N*N-1);

    logic [1:0]     r_state;
    logic [1:0]     w_state_nxt;
    logic [3:0]     r_t;
    logic [3:0]     w_t_nxt;
    logic [3:0]     r_k;
    logic [3:0]     w_k_nxt;
    logic           r_done;
    logic           w_done_nxt;

    logic [N-1:0]   w_line_en;
    logic [2*N-1:0] w_line_elem;

    // Diagonal skew: line i is active while 0 <= t-i <= 3 and reads element t-i.
    // A 5-bit difference keeps the sign so lines not yet started stay off.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_line
            localparam logic [4:0] c_LINE = 5'(gi);
            logic [4:0] w_diff;
            assign w_diff                = {1'b0, r_t} - c_LINE;
            assign w_line_en[gi]         = ~w_diff[4] & (w_diff[3:2] == 2'b00);
            assign w_line_elem[2*gi +: 2] = w_line_en[gi] ? w_diff[1:0] : 2'b00;
        end
    endgenerate

    // State, step counter, result index and done flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_t     <= 4'd0;
            r_k     <= 4'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_t     <= w_t_nxt;
            r_k     <= w_k_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state and counter update; FLUSH reuses t as its cycle counter.
    always_comb begin
        w_state_nxt = r_state;
        w_t_nxt     = r_t;
        w_k_nxt     = r_k;
        w_done_nxt  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_nxt = c_ST_FEED;
                    w_t_nxt     = 4'd0;
                end
            end
            c_ST_FEED: begin
                if (r_t == c_FEED_LAST) begin
                    w_state_nxt = c_ST_FLUSH;
                    w_t_nxt     = 4'd0;
                end else begin
                    w_t_nxt = r_t + 4'd1;
                end
            end
            c_ST_FLUSH: begin
                if (r_t == c_FLUSH_LAST) begin
                    w_state_nxt = c_ST_DRAIN;
                    w_t_nxt     = 4'd0;
                    w_k_nxt     = 4'd0;
                end else begin
                    w_t_nxt = r_t + 4'd1;
                end
            end
            c_ST_DRAIN: begin
                if (out_ready) begin
                    if (r_k == c_K_LAST) begin
                        w_state_nxt = c_ST_IDLE;
                        w_k_nxt     = 4'd0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_k_nxt = r_k + 4'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Output decode from registered state only.
    always_comb begin
        busy      = (r_state != c_ST_IDLE);
        done      = r_done;
        rd_en_a   = '0;
        rd_elem_a = '0;
        rd_en_b   = '0;
        rd_elem_b = '0;
        array_we  = 1'b0;
        out_row   = 2'b00;
        out_col   = 2'b00;
        out_valid = 1'b0;
        case (r_state)
            c_ST_FEED: begin
                rd_en_a   = w_line_en;
                rd_elem_a = w_line_elem;
                rd_en_b   = w_line_en;
                rd_elem_b = w_line_elem;
                array_we  = 1'b1;
            end
            c_ST_FLUSH: begin
                array_we = 1'b1;
            end
            c_ST_DRAIN: begin
                out_valid = 1'b1;
                out_row   = r_k[3:2];
                out_col   = r_k[1:0];
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_tpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tpu_sequencer
//  Brief    : Scoreboard bench for tpu_sequencer. Stimulus pushes expected
//             per-cycle output vectors, result addresses and done cycles;
//             a negedge monitor pops and compares them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tpu_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic [3:0] rd_en_a;
    logic [7:0] rd_elem_a;
    logic [3:0] rd_en_b;
    logic [7:0] rd_elem_b;
    logic       array_we;
    logic [1:0] out_row;
    logic [1:0] out_col;
    logic       out_valid;
    logic       out_ready;

    tpu_sequencer #(
        .N            (4),
        .FLUSH_CYCLES (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rd_en_a   (rd_en_a),
        .rd_elem_a (rd_elem_a),
        .rd_en_b   (rd_en_b),
        .rd_elem_b (rd_elem_b),
        .array_we  (array_we),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Hand-computed FEED pattern for t = 0..9 (cycles 1..10 after start).
    localparam logic [3:0] EN_T [0:9] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE,
                                          4'hC, 4'h8, 4'h0, 4'h0, 4'h0};
    localparam logic [7:0] EL_T [0:9] = '{8'h00, 8'h01, 8'h06, 8'h1B, 8'h6C,
                                          8'hB0, 8'hC0, 8'h00, 8'h00, 8'h00};

    typedef struct {
        int          cyc;
        logic [31:0] vec;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] res_q[$];
    int         done_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int ecnt    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: value seen at a negedge is the index of the last posedge.
    always @(posedge clk) ecnt <= ecnt + 1;

    initial begin
        #20000;
        $display("FAIL watchdog: run did not complete, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] pack(input logic b, input logic d, input logic we,
                                         input logic v, input logic [1:0] row,
                                         input logic [1:0] col, input logic [3:0] en,
                                         input logic [7:0] el);
        return {b, d, we, v, row, col, en, en, el, el};
    endfunction

    // Push expected vectors for one run whose start is sampled at edge t0.
    // Cycle c of the run is observed at the negedge with ecnt == t0+c-1.
    task automatic push_expect(input int t0, input int bp_len, input int abort_c);
        int   last;
        int   idx;
        int   k;
        exp_t e;
        last = (abort_c != 0) ? abort_c + 1 : 28 + bp_len;
        for (int c = 1; c <= last; c++) begin
            e.cyc = t0 + c - 1;
            if (abort_c != 0 && c >= abort_c) begin
                e.vec = 32'h0;
            end else if (c <= 10) begin
                e.vec = pack(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, EN_T[c-1], EL_T[c-1]);
            end else if (c == 11) begin
                e.vec = pack(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 4'h0, 8'h00);
            end else if (c < 28 + bp_len) begin
                idx = c - 12;
                if (idx <= 5)               k = idx;
                else if (idx - bp_len < 5)  k = 5;
                else                        k = idx - bp_len;
                e.vec = pack(1'b1, 1'b0, 1'b0, 1'b1, 2'(k / 4), 2'(k % 4), 4'h0, 8'h00);
            end else begin
                e.vec = pack(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 4'h0, 8'h00);
            end
            exp_q.push_back(e);
        end
        if (abort_c == 0) begin
            for (int r = 0; r < 16; r++) res_q.push_back(4'(r));
            done_q.push_back(t0 + 27 + bp_len);
        end
    endtask

    task automatic goto_edge(input int target);
        while (ecnt < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one run: start in cycle 0, optional stray starts, a 3-cycle stall
    // at k=5 (cycles 17..), an optional reset pulse, optional chained start.
    task automatic drive(input int t0, input int bp_len, input bit stray,
                         input int abort_c, input bit chain);
        int last;
        last = (abort_c != 0) ? abort_c + 1 : 28 + bp_len;
        goto_edge(t0 - 1);
        start = 1'b1;
        for (int c = 1; c <= last; c++) begin
            goto_edge(t0 + c - 1);
            start     = (stray && (c == 3 || c == 15)) || (chain && c == last);
            out_ready = !(c >= 17 && c < 17 + bp_len);
            if (c == abort_c) begin
                #1;
                rst = 1'b1;
            end else begin
                rst = 1'b0;
            end
        end
    endtask

    exp_t        mon_e;
    logic [31:0] mon_act;
    logic [3:0]  mon_r;
    int          mon_d;

    // Monitor: compares scheduled vectors, accepted results and done pulses.
    always @(negedge clk) begin
        mon_act = {busy, done, array_we, out_valid, out_row, out_col,
                   rd_en_a, rd_en_b, rd_elem_a, rd_elem_b};
        if (exp_q.size() > 0 && exp_q[0].cyc < ecnt) begin
            n_tests++;
            n_fail++;
            $display("FAIL vec_missed: expected vector for edge %0d not checked (now %0d)",
                     exp_q[0].cyc, ecnt);
            exp_q.delete(0);
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == ecnt) begin
            mon_e = exp_q.pop_front();
            n_tests++;
            if (mon_act !== mon_e.vec) begin
                n_fail++;
                $display("FAIL vec@%0d busy,done,we,vld,row,col,enA,enB,elA,elB: got %08h want %08h",
                         ecnt, mon_act, mon_e.vec);
            end
        end
        if (out_valid && out_ready) begin
            n_tests++;
            if (res_q.size() == 0) begin
                n_fail++;
                $display("FAIL result_unexpected@%0d: got row %0d col %0d, none expected",
                         ecnt, out_row, out_col);
            end else begin
                mon_r = res_q.pop_front();
                if ({out_row, out_col} !== mon_r) begin
                    n_fail++;
                    $display("FAIL result_order@%0d: got row %0d col %0d want row %0d col %0d",
                             ecnt, out_row, out_col, mon_r[3:2], mon_r[1:0]);
                end
            end
        end
        if (done) begin
            n_tests++;
            if (done_q.size() == 0) begin
                n_fail++;
                $display("FAIL done_unexpected@%0d: got done=1, none expected", ecnt);
            end else begin
                mon_d = done_q.pop_front();
                if (mon_d != ecnt) begin
                    n_fail++;
                    $display("FAIL done_cycle: got edge %0d want edge %0d", ecnt, mon_d);
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b1;

        // Reset state while held, then idle after release.
        goto_edge(1);
        mon_e.cyc = 1;  mon_e.vec = 32'h0;  exp_q.push_back(mon_e);
        goto_edge(2);
        rst = 1'b0;
        mon_e.cyc = 2;  mon_e.vec = 32'h0;  exp_q.push_back(mon_e);
        mon_e.cyc = 3;  mon_e.vec = 32'h0;  exp_q.push_back(mon_e);

        // Basic run, out_ready held high: done in cycle 28.
        push_expect(6, 0, 0);
        drive(6, 0, 1'b0, 0, 1'b0);

        // Backpressure: 3 stall cycles at k=5, done slips to cycle 31.
        push_expect(38, 3, 0);
        drive(38, 3, 1'b0, 0, 1'b0);

        // Stray starts in cycles 3 and 15, then back-to-back start in cycle 28.
        push_expect(72, 0, 0);
        push_expect(100, 0, 0);
        drive(72, 0, 1'b1, 0, 1'b1);
        drive(100, 0, 1'b0, 0, 1'b0);

        // Asynchronous reset mid-FEED in cycle 6, then a full clean run.
        push_expect(132, 0, 6);
        drive(132, 0, 1'b0, 6, 1'b0);
        push_expect(142, 0, 0);
        drive(142, 0, 1'b0, 0, 1'b0);

        goto_edge(176);

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL vec_queue_drain: got %0d pending want 0", exp_q.size());
        end
        n_tests++;
        if (res_q.size() != 0) begin
            n_fail++;
            $display("FAIL result_queue_drain: got %0d pending want 0", res_q.size());
        end
        n_tests++;
        if (done_q.size() != 0) begin
            n_fail++;
            $display("FAIL done_queue_drain: got %0d pending want 0", done_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
